// File: rtl/fifo_key_ctrl.sv
// Push-button and DIP-switch conditioning for the 4-bit sync FIFO: synchronise, debounce,
// and turn each accepted key press into one clean FIFO strobe or a level clear.
//
// Per-key debounce FSM (read, write, clear), advancing only on tick cycles:
//   state     | meaning
//   IDLE      | key accepted as released
//   PRESS_CHK | key seen pressed, counting consecutive pressed samples
//   HELD      | key accepted as pressed (also the reset state)
//   REL_CHK   | key seen released, counting consecutive released samples
module fifo_key_ctrl #(
  parameter int TICK_DIV   = 4,
  parameter int DEBOUNCE_N = 3,
  parameter int WIDTH      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_read,
  input  logic             key_write,
  input  logic             key_clear,
  input  logic [WIDTH-1:0] sw_data,
  output logic             read,
  output logic             write,
  output logic [WIDTH-1:0] fifo_in,
  output logic             fifo_reset
);

  localparam int               TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0]        CNT_DONE  = 4'(DEBOUNCE_N);
  localparam int                NKEY      = 3;
  localparam int                KEY_RD    = 0;
  localparam int                KEY_WR    = 1;
  localparam int                KEY_CLR   = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_state_e;

  logic [NKEY-1:0]   key_s1, key_s2;
  logic [WIDTH-1:0]  sw_s1, sw_s2;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  key_state_e state_q   [NKEY];
  key_state_e state_nxt [NKEY];
  logic [3:0] cnt_q     [NKEY];
  logic [3:0] cnt_nxt   [NKEY];

  logic [1:0] accept;
  logic       clr_active_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= {key_clear, key_write, key_read};
      key_s2 <= key_s1;
      sw_s1  <= sw_data;
      sw_s2  <= sw_s1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NKEY; k++) begin
        state_q[k] <= HELD;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NKEY; k++) begin
        state_q[k] <= state_nxt[k];
        cnt_q[k]   <= cnt_nxt[k];
      end
    end
  end

  // FSM next state
  always_comb begin
    for (int k = 0; k < NKEY; k++) begin
      state_nxt[k] = state_q[k];
      cnt_nxt[k]   = cnt_q[k];
      if (tick) begin
        case (state_q[k])
          IDLE: begin
            if (key_s2[k]) begin
              state_nxt[k] = PRESS_CHK;
              cnt_nxt[k]   = 4'd1;
            end
          end
          PRESS_CHK: begin
            if (!key_s2[k]) begin
              state_nxt[k] = IDLE;
              cnt_nxt[k]   = '0;
            end else if (cnt_q[k] + 4'd1 == CNT_DONE) begin
              state_nxt[k] = HELD;
              cnt_nxt[k]   = '0;
            end else begin
              cnt_nxt[k]   = cnt_q[k] + 4'd1;
            end
          end
          HELD: begin
            if (!key_s2[k]) begin
              state_nxt[k] = REL_CHK;
              cnt_nxt[k]   = 4'd1;
            end
          end
          REL_CHK: begin
            if (key_s2[k]) begin
              state_nxt[k] = HELD;
              cnt_nxt[k]   = '0;
            end else if (cnt_q[k] + 4'd1 == CNT_DONE) begin
              state_nxt[k] = IDLE;
              cnt_nxt[k]   = '0;
            end else begin
              cnt_nxt[k]   = cnt_q[k] + 4'd1;
            end
          end
          default: begin
            state_nxt[k] = HELD;
            cnt_nxt[k]   = '0;
          end
        endcase
      end
    end
  end

  // FSM outputs: accept events for read/write, and the clear level about to be registered
  always_comb begin
    accept = '0;
    for (int k = 0; k < 2; k++) begin
      accept[k] = tick && (state_q[k] == PRESS_CHK) && key_s2[k] &&
                  (cnt_q[k] + 4'd1 == CNT_DONE);
    end
    clr_active_nxt = (state_nxt[KEY_CLR] == HELD) || (state_nxt[KEY_CLR] == REL_CHK);
  end

  // Clear uses the next clear state so a clear qualifying on the same tick beats read/write;
  // the clear FSM starts in HELD, so the FIFO is held clear until the clear key is seen released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read       <= 1'b0;
      write      <= 1'b0;
      fifo_reset <= 1'b0;
      fifo_in    <= '0;
    end else begin
      read       <= accept[KEY_RD] && !clr_active_nxt;
      write      <= accept[KEY_WR] && !clr_active_nxt;
      fifo_reset <= clr_active_nxt;
      if (accept[KEY_WR] && !clr_active_nxt) fifo_in <= sw_s2;
    end
  end

endmodule

// File: tb/tb_fifo_key_ctrl.sv
// Bench for fifo_key_ctrl: directed key scenarios plus random key activity, checked every
// cycle against a debounce model based on runs of identical tick samples.
module tb_fifo_key_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int DEBOUNCE_N = 3;
  localparam int WIDTH      = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             key_read = 1'b0, key_write = 1'b0, key_clear = 1'b0;
  logic [WIDTH-1:0] sw_data = '0;
  logic             read, write, fifo_reset;
  logic [WIDTH-1:0] fifo_in;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  fifo_key_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .DEBOUNCE_N(DEBOUNCE_N),
    .WIDTH     (WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_read  (key_read),
    .key_write (key_write),
    .key_clear (key_clear),
    .sw_data   (sw_data),
    .read      (read),
    .write     (write),
    .fifo_in   (fifo_in),
    .fifo_reset(fifo_reset)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a key's accepted level flips once DEBOUNCE_N consecutive tick samples
  // disagree with it; a flip to pressed is one accept event.
  int               m_count = 0;
  logic [2:0]       m_s1, m_s2;
  logic [WIDTH-1:0] m_sw1, m_sw2;
  int               run_len  [3];
  logic             last_smp [3];
  logic             level    [3];
  logic             ev       [3];
  logic             m_smp;
  logic             exp_read, exp_write, exp_fifo_reset;
  logic [WIDTH-1:0] exp_fifo_in;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_count = 0;
      m_s1 = '0; m_s2 = '0; m_sw1 = '0; m_sw2 = '0;
      for (int k = 0; k < 3; k++) begin
        run_len[k] = 0; last_smp[k] = 1'b0; level[k] = 1'b1; ev[k] = 1'b0;
      end
      exp_read = 1'b0; exp_write = 1'b0; exp_fifo_reset = 1'b0; exp_fifo_in = '0;
    end else begin
      for (int k = 0; k < 3; k++) ev[k] = 1'b0;
      if (m_count == TICK_DIV - 1) begin
        for (int k = 0; k < 3; k++) begin
          m_smp = m_s2[k];
          if (run_len[k] > 0 && m_smp == last_smp[k]) run_len[k] = run_len[k] + 1;
          else run_len[k] = 1;
          last_smp[k] = m_smp;
          if (m_smp != level[k] && run_len[k] >= DEBOUNCE_N) begin
            level[k] = m_smp;
            ev[k]    = m_smp;
          end
        end
        m_count = 0;
      end else begin
        m_count = m_count + 1;
      end
      exp_fifo_reset = level[2];
      exp_read       = ev[0] && !level[2];
      exp_write      = ev[1] && !level[2];
      if (exp_write) exp_fifo_in = m_sw2;
      m_s2  = m_s1;
      m_s1  = {key_clear, key_write, key_read};
      m_sw2 = m_sw1;
      m_sw1 = sw_data;
    end
  end

  bit chk_en = 1'b0;
  int rd_pulses = 0, wr_pulses = 0, both_pulses = 0, clr_cycles = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      check("read",       32'(read),       32'(exp_read));
      check("write",      32'(write),      32'(exp_write));
      check("fifo_reset", 32'(fifo_reset), 32'(exp_fifo_reset));
      check("fifo_in",    32'(fifo_in),    32'(exp_fifo_in));
    end
    if (reset) begin
      if (read)          rd_pulses++;
      if (write)         wr_pulses++;
      if (read && write) both_pulses++;
      if (fifo_reset)    clr_cycles++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_read",       32'(read),       32'd0);
    check("rst_write",      32'(write),      32'd0);
    check("rst_fifo_reset", 32'(fifo_reset), 32'd0);
    check("rst_fifo_in",    32'(fifo_in),    32'd0);
    repeat (cycles) @(negedge clock);
    reset = 1'b1;
  endtask

  int r0, w0, b0, c0;

  initial begin
    do_reset(3);
    chk_en = 1'b1;
    idle(30);
    check("post_rst_clear_released", 32'(fifo_reset), 32'd0);

    // clean write press
    sw_data = 4'hA;
    r0 = rd_pulses; w0 = wr_pulses; c0 = clr_cycles;
    key_write = 1'b1;
    idle(40);
    check("t1_write_pulses", 32'(wr_pulses - w0), 32'd1);
    check("t1_fifo_in",      32'(fifo_in),        32'hA);
    check("t1_read_pulses",  32'(rd_pulses - r0), 32'd0);
    check("t1_clear_cycles", 32'(clr_cycles - c0), 32'd0);
    key_write = 1'b0;
    idle(20);

    // bounce rejection: one sample per value, then a stable press
    r0 = rd_pulses;
    for (int i = 0; i < 4; i++) begin
      key_read = (i % 2 == 0);
      idle(TICK_DIV);
    end
    check("t2_bounce_pulses", 32'(rd_pulses - r0), 32'd0);
    key_read = 1'b1;
    idle(20);
    check("t2_read_pulses", 32'(rd_pulses - r0), 32'd1);
    key_read = 1'b0;
    idle(20);

    // hold and repeat; switch changes while held are ignored
    w0 = wr_pulses;
    sw_data = 4'h3;
    key_write = 1'b1;
    idle(30);
    check("t3_first_fifo_in", 32'(fifo_in), 32'h3);
    for (int i = 0; i < 5; i++) begin
      sw_data = WIDTH'($urandom);
      idle(34);
    end
    check("t3_hold_fifo_in", 32'(fifo_in),        32'h3);
    check("t3_hold_pulses",  32'(wr_pulses - w0), 32'd1);
    key_write = 1'b0;
    idle(20);
    sw_data = 4'hC;
    key_write = 1'b1;
    idle(30);
    check("t3_repeat_pulses",  32'(wr_pulses - w0), 32'd2);
    check("t3_repeat_fifo_in", 32'(fifo_in),        32'hC);
    key_write = 1'b0;
    idle(20);

    // simultaneous read and write
    r0 = rd_pulses; w0 = wr_pulses; b0 = both_pulses;
    key_read = 1'b1; key_write = 1'b1;
    idle(30);
    check("t4_read_pulses",  32'(rd_pulses - r0),   32'd1);
    check("t4_write_pulses", 32'(wr_pulses - w0),   32'd1);
    check("t4_same_cycle",   32'(both_pulses - b0), 32'd1);
    key_read = 1'b0; key_write = 1'b0;
    idle(20);

    // clear priority
    w0 = wr_pulses;
    key_clear = 1'b1;
    idle(30);
    check("t5_clear_on", 32'(fifo_reset), 32'd1);
    key_write = 1'b1;
    idle(30);
    check("t5_clear_held", 32'(fifo_reset), 32'd1);
    key_clear = 1'b0;
    idle(30);
    check("t5_clear_off",     32'(fifo_reset),      32'd0);
    check("t5_write_pulses",  32'(wr_pulses - w0),  32'd0);
    key_write = 1'b0;
    idle(20);

    // reset in the middle of a press check
    key_write = 1'b1;
    idle(6);
    w0 = wr_pulses;
    do_reset(3);
    idle(50);
    check("t6_held_through_reset", 32'(wr_pulses - w0), 32'd0);
    key_write = 1'b0;
    idle(20);
    key_write = 1'b1;
    idle(30);
    check("t6_repress_pulses", 32'(wr_pulses - w0), 32'd1);
    key_write = 1'b0;
    idle(20);

    // random key activity with bounce-length and settled durations
    for (int i = 0; i < 80; i++) begin
      key_read  = 1'($urandom_range(0, 1));
      key_write = 1'($urandom_range(0, 1));
      key_clear = ($urandom_range(0, 3) == 0);
      sw_data   = WIDTH'($urandom);
      if (i == 40) do_reset(2);
      idle(int'($urandom_range(1, 25)));
    end
    key_read = 1'b0; key_write = 1'b0; key_clear = 1'b0;
    idle(40);
    check("final_clear_released", 32'(fifo_reset), 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_key_ctrl.md
Name: fifo_key_ctrl

Overview:
- Input-conditioning stage directly upstream of the 4-bit sync FIFO on the EDA board.
- Turns raw push-buttons and DIP switches into clean, clock-synchronous FIFO controls:
  - single-cycle read/write strobes;
  - a write-data bus that is stable while the write strobe is high;
  - a level clear.
- Removes contact bounce and guarantees exactly one FIFO operation per physical key press.

Parameters:
- TICK_DIV, 4, clock cycles per debounce sample tick (board build uses 250000); minimum 2.
- DEBOUNCE_N, 3, consecutive identical samples needed to accept a key change; range 2..15.
- WIDTH, 4, data switch width; equals FIFO width.

Ports:
- clock  in  1  system clock, shared with the FIFO.
- reset  in  1  asynchronous, active-low reset.
- key_read  in  1  raw read button, 1 = pressed, asynchronous.
- key_write  in  1  raw write button, 1 = pressed, asynchronous.
- key_clear  in  1  raw clear button, 1 = pressed, asynchronous.
- sw_data  in  WIDTH  raw data switches, asynchronous.
- read  out  1  one-cycle read strobe to FIFO.
- write  out  1  one-cycle write strobe to FIFO.
- fifo_in  out  WIDTH  write data to FIFO.
- fifo_reset  out  1  active-high level clear to FIFO.

Behaviour:
- Reset values (immediately on reset=0, clock not required):
  - read = 0, write = 0, fifo_reset = 0, fifo_in = 0.
  - Tick counter = 0; synchronizers = 0.
  - All key FSMs = HELD with sample count 0.
- Synchronization: every raw input passes through two flops before any use.
- Tick generator:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for one cycle when count == TICK_DIV-1.
- Per-key FSM, one each for read/write/clear, advancing only on tick cycles. Each FSM has a sample counter cnt of 4 bits (saturating is not needed; it is cleared on every state change).
  - IDLE: sample 1 → PRESS_CHK with cnt = 1.
  - PRESS_CHK:
    - sample 1 → cnt+1; if cnt+1 == DEBOUNCE_N → HELD and raise the accept event.
    - sample 0 → IDLE.
  - HELD: sample 0 → REL_CHK with cnt = 1.
  - REL_CHK:
    - sample 0 → cnt+1; if cnt+1 == DEBOUNCE_N → IDLE.
    - sample 1 → HELD.
- Reset lands in HELD. A key held through reset release produces no strobe until it has been released for DEBOUNCE_N samples and pressed again.
- Strobes:
  - read/write go high exactly one cycle, on the cycle after the tick that made the read/write FSM enter HELD.
  - Latency from a clean input edge to the strobe is at most 2 + DEBOUNCE_N*TICK_DIV + 1 cycles.
  - A held key never repeats.
- Data capture:
  - fifo_in loads the synchronized sw_data on the same clock edge that sets write = 1.
  - fifo_in then holds its value until the next write strobe.
  - Switch changes at any other time do not affect fifo_in.
- Clear:
  - fifo_reset = 1 while the clear FSM is in HELD or REL_CHK, 0 otherwise.
  - While fifo_reset = 1, read and write are forced to 0. Accept events occurring then are discarded, not queued.
- Simultaneous events:
  - If read and write qualify on the same tick, both strobes are high in the same cycle (FIFO 2'b11 bypass path).
  - If they qualify on different ticks, the strobes are separate.
  - Clear qualifying on the same tick as read/write wins; the strobes are suppressed.
- Reset mid-operation: asserting reset mid-debounce aborts it with no strobe. The outputs return to their reset values asynchronously.

Test Plan:
1. Clean write press (TICK_DIV=4, DEBOUNCE_N=3):
   - Stimulus: sw_data=4'hA, key_write 0→1 held for 40 cycles after a prior release qualified.
   - Required: write=1 for exactly one cycle, fifo_in=4'hA in that cycle, fifo_in stays 4'hA afterwards; read and fifo_reset stay 0.
2. Bounce rejection:
   - Stimulus: key_read toggles 1,0,1,0 on alternate ticks, then held 1 for 3 ticks.
   - Required: exactly one read pulse, 1 cycle after the 3rd stable tick; no pulse during the bouncing.
3. Hold and repeat:
   - Stimulus: key_write held 200 cycles, released 20 cycles, pressed again.
   - Required: exactly two write pulses; sw_data changes while the key is held do not alter fifo_in.
4. Simultaneous:
   - Stimulus: key_read and key_write rise in the same cycle.
   - Required: read=1 and write=1 in the same single cycle.
5. Clear priority:
   - Stimulus: key_clear held, then key_write pressed during the clear.
   - Required: fifo_reset=1 from clear qualification until release qualification; no write pulse, even after clear releases while write is still held.
6. Reset mid-press:
   - Stimulus: key_write high, reset=0 for 3 cycles during PRESS_CHK, key_write held after reset=1 for 50 cycles.
   - Required: all outputs 0 immediately on reset=0; no write pulse until key_write is released ≥3 ticks and pressed again.
